// File: rtl/pid_seq_pkg.sv
// Shared definitions for the PID move sequencer.
// Holds the position width, the sequencer state encoding and the
// wrap-aware position difference / magnitude helpers.
package pid_seq_pkg;

    localparam int POS_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SLEW   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_FAULT  = 2'd3
    } seq_state_t;

    // a - b taken as two's complement, i.e. the shortest path across wrap.
    function automatic logic signed [POS_W-1:0] pos_diff(
        input logic [POS_W-1:0] a,
        input logic [POS_W-1:0] b
    );
        return signed'(a - b);
    endfunction

    // Magnitude is one bit wider so the most negative difference maps to 2^(POS_W-1).
    function automatic logic [POS_W:0] pos_mag(input logic signed [POS_W-1:0] d);
        logic [POS_W:0] ext;
        ext = {d[POS_W-1], d};
        if (d[POS_W-1]) begin
            return (~ext) + {{POS_W{1'b0}}, 1'b1};
        end else begin
            return ext;
        end
    endfunction

    // Wrap-aware distance |a - b|.
    function automatic logic [POS_W:0] pos_dist(
        input logic [POS_W-1:0] a,
        input logic [POS_W-1:0] b
    );
        return pos_mag(pos_diff(a, b));
    endfunction

endpackage

// File: rtl/pid_tick_gen.sv
// Control-tick generator for the PID position loop.
// The divider runs 0..TICK_DIV-1 continuously; Pid_Tick is a registered
// one-cycle strobe in the cycle after the divider reaches TICK_DIV-1.
// Ports:
//   Clock    - system clock
//   Reset    - asynchronous, active-high reset
//   Pid_Tick - one-cycle sample strobe
module pid_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic Clock,
    input  logic Reset,
    output logic Pid_Tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Free-running divider and registered tick strobe.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            tick_r <= 1'b0;
        end
    end

    assign Pid_Tick = tick_r;

endmodule

// File: rtl/pid_move_sequencer.sv
// Point-to-point move sequencer for the encoder-based PID position loop.
// Accepts targets over valid/ready, slews the PID setpoint at a bounded
// rate per control tick, waits for the encoder to settle inside a window,
// and drops the drive enable when the following error grows too large.
// Ports:
//   Clock, Reset         - system clock, asynchronous active-high reset
//   Cmd_Valid/Cmd_Pos    - move request and target position
//   Cmd_Ready            - request accepted when Cmd_Valid & Cmd_Ready
//   Abort                - stop move, hold present setpoint
//   Fault_Clr            - leave FAULT
//   EncCount             - encoder counter value
//   Setpoint             - PID Pos input
//   Pid_Tick             - one-cycle PID sample strobe
//   Drive_En             - motor drive enable
//   Busy/Done/Fault      - move status
module pid_move_sequencer
    import pid_seq_pkg::*;
#(
    parameter int               TICK_DIV     = 50000,
    parameter logic [POS_W-1:0] STEP_MAX     = 18'd64,
    parameter logic [POS_W-1:0] FERR_LIM     = 18'h01000,
    parameter logic [POS_W-1:0] WIN          = 18'd8,
    parameter int               SETTLE_TICKS = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Cmd_Valid,
    input  logic [POS_W-1:0] Cmd_Pos,
    output logic             Cmd_Ready,
    input  logic             Abort,
    input  logic             Fault_Clr,
    input  logic [POS_W-1:0] EncCount,
    output logic [POS_W-1:0] Setpoint,
    output logic             Pid_Tick,
    output logic             Drive_En,
    output logic             Busy,
    output logic             Done,
    output logic             Fault
);

    localparam int SC_W = $clog2(SETTLE_TICKS + 1);
    localparam logic [SC_W-1:0] SC_DONE = SC_W'(SETTLE_TICKS);

    seq_state_t       state_r, state_s;
    logic [POS_W-1:0] setpoint_r, setpoint_s;
    logic [POS_W-1:0] target_r, target_s;
    logic             hold_r, hold_s;
    logic [SC_W-1:0]  settle_r, settle_s;
    logic             done_s;
    logic             cmd_ready_r, drive_en_r, busy_r, done_r, fault_r;

    logic             tick_s;
    logic signed [POS_W-1:0] slew_d_s;
    logic             ferr_s;
    logic             in_win_s;
    logic [SC_W-1:0]  settle_inc_s;

    pid_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .Clock    (Clock),
        .Reset    (Reset),
        .Pid_Tick (tick_s)
    );

    // Limit checks; following error uses the setpoint before this tick's update.
    always_comb begin
        slew_d_s     = pos_diff(target_r, setpoint_r);
        ferr_s       = (pos_dist(setpoint_r, EncCount) > {1'b0, FERR_LIM});
        in_win_s     = (pos_dist(target_r, EncCount) <= {1'b0, WIN});
        settle_inc_s = settle_r + SC_W'(1);
    end

    // Next-state logic; priority is fault > abort > step/settle.
    always_comb begin
        state_s    = state_r;
        setpoint_s = setpoint_r;
        target_s   = target_r;
        hold_s     = hold_r;
        settle_s   = settle_r;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Cmd_Valid && cmd_ready_r) begin
                    target_s = Cmd_Pos;
                    // Bumpless start: only re-seed from the encoder when not holding.
                    if (!hold_r) begin
                        setpoint_s = EncCount;
                    end else begin
                        setpoint_s = setpoint_r;
                    end
                    hold_s  = 1'b1;
                    state_s = ST_SLEW;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SLEW: begin
                if (tick_s && ferr_s) begin
                    hold_s  = 1'b0;
                    state_s = ST_FAULT;
                end else if (Abort) begin
                    target_s = setpoint_r;
                    state_s  = ST_IDLE;
                end else if (tick_s) begin
                    if (pos_mag(slew_d_s) <= {1'b0, STEP_MAX}) begin
                        setpoint_s = target_r;
                        settle_s   = {SC_W{1'b0}};
                        state_s    = ST_SETTLE;
                    end else if (slew_d_s[POS_W-1]) begin
                        setpoint_s = setpoint_r - STEP_MAX;
                    end else begin
                        setpoint_s = setpoint_r + STEP_MAX;
                    end
                end else begin
                    state_s = ST_SLEW;
                end
            end
            ST_SETTLE: begin
                if (tick_s && ferr_s) begin
                    hold_s  = 1'b0;
                    state_s = ST_FAULT;
                end else if (Abort) begin
                    target_s = setpoint_r;
                    state_s  = ST_IDLE;
                end else if (tick_s) begin
                    if (in_win_s) begin
                        settle_s = settle_inc_s;
                        if (settle_inc_s == SC_DONE) begin
                            done_s  = 1'b1;
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_SETTLE;
                        end
                    end else begin
                        settle_s = {SC_W{1'b0}};
                        state_s  = ST_SETTLE;
                    end
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_FAULT: begin
                hold_s = 1'b0;
                if (Fault_Clr) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FAULT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs derived from the next state.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            setpoint_r  <= {POS_W{1'b0}};
            target_r    <= {POS_W{1'b0}};
            hold_r      <= 1'b0;
            settle_r    <= {SC_W{1'b0}};
            cmd_ready_r <= 1'b1;
            drive_en_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            setpoint_r  <= setpoint_s;
            target_r    <= target_s;
            hold_r      <= hold_s;
            settle_r    <= settle_s;
            cmd_ready_r <= (state_s == ST_IDLE);
            drive_en_r  <= (state_s != ST_FAULT) && hold_s;
            busy_r      <= (state_s == ST_SLEW) || (state_s == ST_SETTLE);
            done_r      <= done_s;
            fault_r     <= (state_s == ST_FAULT);
        end
    end

    assign Cmd_Ready = cmd_ready_r;
    assign Setpoint  = setpoint_r;
    assign Pid_Tick  = tick_s;
    assign Drive_En  = drive_en_r;
    assign Busy      = busy_r;
    assign Done      = done_r;
    assign Fault     = fault_r;

endmodule
